prog_delay_line: RTL and testbench

//  Runtime-programmable, multi-channel sample delay line with a circular buffer.

---
 rtl/prog_delay_line.sv | 106 ++++++++++
 tb/tb_prog_delay_line.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/prog_delay_line.sv
// Runtime-programmable multi-channel sample delay line built on a circular buffer.
// Optional half-delay tap output enabled by defining PDL_MID_TAP_EN.
module prog_delay_line #(
    parameter int WIDTH         = 16,
    parameter int CHANNELS      = 1,
    parameter int MAX_DEPTH     = 64,
    parameter int DEFAULT_DELAY = 31,
    localparam int DW           = $clog2(MAX_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic                      valid_in,
    input  logic [DW-1:0]             delay_in,
    input  logic                      delay_load,
    output logic [CHANNELS*WIDTH-1:0] dout,
    output logic                      valid_out,
    output logic [CHANNELS*WIDTH-1:0] dout_mid,
    output logic [DW-1:0]             delay_cur,
    output logic                      primed,
    output logic                      delay_err
);

    localparam int            AW    = $clog2(MAX_DEPTH);
    localparam int            CW    = CHANNELS * WIDTH;
    localparam logic [DW-1:0] MAX_D = DW'(MAX_DEPTH);

    logic [CW-1:0] mem [0:MAX_DEPTH-1];
    logic [AW-1:0] wp;
    logic [DW-1:0] fill;
    logic [CW-1:0] tap_full;
    logic          hit;

    // Slot holding the sample written d valid cycles ago; d ranges 0..MAX_DEPTH.
    function automatic logic [AW-1:0] tap_addr(input logic [AW-1:0] w, input logic [DW-1:0] d);
        logic [DW:0] w_ext;
        logic [DW:0] sum;
        w_ext = (DW + 1)'(w);
        if (w_ext >= {1'b0, d})
            sum = w_ext - {1'b0, d};
        else
            sum = w_ext + (DW + 1)'(MAX_DEPTH) - {1'b0, d};
        return sum[AW-1:0];
    endfunction

    assign hit      = (fill >= delay_cur);
    assign primed   = hit;
    assign tap_full = (delay_cur == '0) ? din : mem[tap_addr(wp, delay_cur)];

    // NOTE: the buffer has no reset so it can map onto RAM; reads are only used once fill covers them.
    always_ff @(posedge clk) begin
        if (valid_in)
            mem[wp] <= din;
    end

    // NOTE: non-blocking updates make the tap read above see the old slot contents (read-before-write).
    always_ff @(posedge clk) begin
        if (rst) begin
            wp        <= '0;
            fill      <= '0;
            delay_cur <= DW'(DEFAULT_DELAY);
            delay_err <= 1'b0;
            valid_out <= 1'b0;
            dout      <= '0;
        end else begin
            if (valid_in) begin
                if (wp == AW'(MAX_DEPTH - 1))
                    wp <= '0;
                else
                    wp <= wp + AW'(1);
            end

            // A new delay re-primes the line even if this cycle also carries a sample.
            if (delay_load)
                fill <= '0;
            else if (valid_in && fill != MAX_D)
                fill <= fill + DW'(1);

            if (delay_load)
                delay_cur <= (delay_in > MAX_D) ? MAX_D : delay_in;
            delay_err <= delay_load && (delay_in > MAX_D);

            valid_out <= valid_in && hit;
            if (valid_in)
                dout <= hit ? tap_full : '0;
        end
    end

`ifdef PDL_MID_TAP_EN
    logic [DW-1:0] half_delay;
    logic [CW-1:0] tap_mid;

    assign half_delay = delay_cur >> 1;
    assign tap_mid    = (half_delay == '0) ? din : mem[tap_addr(wp, half_delay)];

    always_ff @(posedge clk) begin
        if (rst)
            dout_mid <= '0;
        else if (valid_in)
            dout_mid <= hit ? tap_mid : '0;
    end
`else
    assign dout_mid = '0;
`endif

endmodule

// File: tb/tb_prog_delay_line.sv
// Directed self-checking bench for prog_delay_line: ramps, gaps, reloads, clamping and reset.
module tb_prog_delay_line;

    localparam int WIDTH         = 16;
    localparam int CHANNELS      = 1;
    localparam int MAX_DEPTH     = 64;
    localparam int DEFAULT_DELAY = 31;
    localparam int DW            = $clog2(MAX_DEPTH + 1);

    logic                      clk = 1'b0;
    logic                      rst;
    logic [CHANNELS*WIDTH-1:0] din;
    logic                      valid_in;
    logic [DW-1:0]             delay_in;
    logic                      delay_load;
    logic [CHANNELS*WIDTH-1:0] dout;
    logic                      valid_out;
    logic [CHANNELS*WIDTH-1:0] dout_mid;
    logic [DW-1:0]             delay_cur;
    logic                      primed;
    logic                      delay_err;

    int vectors     = 0;
    int miscompares = 0;
    int n           = 0;
    int exp_d       = 0;

    logic [15:0] pat [6] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001, 16'hA5A5, 16'h0000};

    prog_delay_line #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .MAX_DEPTH(MAX_DEPTH), .DEFAULT_DELAY(DEFAULT_DELAY)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .valid_in(valid_in),
        .delay_in(delay_in), .delay_load(delay_load),
        .dout(dout), .valid_out(valid_out), .dout_mid(dout_mid),
        .delay_cur(delay_cur), .primed(primed), .delay_err(delay_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic v, input logic [15:0] d);
        din      = d;
        valid_in = v;
        @(posedge clk);
        #1;
        delay_load = 1'b0;
    endtask

    task automatic load(input int d);
        delay_in   = DW'(d);
        delay_load = 1'b1;
    endtask

    initial begin
        rst = 1'b1; din = '0; valid_in = 1'b0; delay_in = '0; delay_load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout",      32'(dout), 32'(0));
        check("rst_valid",     32'(valid_out), 32'(0));
        check("rst_delay_cur", 32'(delay_cur), 32'(31));
        check("rst_primed",    32'(primed), 32'(0));
        check("rst_err",       32'(delay_err), 32'(0));
        check("rst_mid",       32'(dout_mid), 32'(0));
        rst = 1'b0;

        // Continuous ramp at the default delay of 31.
        for (int i = 1; i <= 39; i++) begin
            n++;
            push(1'b1, WIDTH'(n));
            check("t1_valid",  32'(valid_out), 32'(n >= 32));
            check("t1_dout",   32'(dout), 32'((n >= 32) ? n - 31 : 0));
            check("t1_primed", 32'(primed), 32'(n >= 31));
        end

        // Sample 40 carries a load of 5: it still uses delay 31.
        load(5);
        n++;
        push(1'b1, WIDTH'(n));
        check("t5_old_delay_valid", 32'(valid_out), 32'(1));
        check("t5_old_delay_dout",  32'(dout), 32'(9));
        check("t5_delay_cur",       32'(delay_cur), 32'(5));
        check("t5_reprimed",        32'(primed), 32'(0));
        for (int k = 1; k <= 10; k++) begin
            n++;
            push(1'b1, WIDTH'(n));
            check("t5_valid",  32'(valid_out), 32'(k >= 6));
            check("t5_dout",   32'(dout), 32'((k >= 6) ? n - 5 : 0));
            check("t5_primed", 32'(primed), 32'(k >= 5));
        end

        // Over-range request clamps to MAX_DEPTH and flags a one-cycle error.
        load(100);
        push(1'b0, 16'hDEAD);
        check("t5_clamp",      32'(delay_cur), 32'(64));
        check("t5_err_pulse",  32'(delay_err), 32'(1));
        check("t5_idle_valid", 32'(valid_out), 32'(0));
        check("t5_idle_hold",  32'(dout), 32'(45));
        push(1'b0, 16'hDEAD);
        check("t5_err_clear",  32'(delay_err), 32'(0));

        // Full-depth delay across several pointer wraps.
        for (int k = 1; k <= 200; k++) begin
            n++;
            push(1'b1, WIDTH'(n));
            check("t4_valid",  32'(valid_out), 32'(k >= 65));
            check("t4_dout",   32'(dout), 32'((k >= 65) ? n - 64 : 0));
            check("t4_primed", 32'(primed), 32'(k >= 64));
        end

        // Delay 4 with a valid sample only every third clock.
        load(4);
        push(1'b0, 16'hDEAD);
        check("t2_delay_cur", 32'(delay_cur), 32'(4));
        check("t2_load_hold", 32'(dout), 32'(186));
        for (int k = 1; k <= 12; k++) begin
            n++;
            push(1'b1, WIDTH'(n));
            exp_d = (k >= 5) ? n - 4 : 0;
            check("t2_valid", 32'(valid_out), 32'(k >= 5));
            check("t2_dout",  32'(dout), 32'(exp_d));
            repeat (2) begin
                push(1'b0, 16'hDEAD);
                check("t2_gap_valid", 32'(valid_out), 32'(0));
                check("t2_gap_hold",  32'(dout), 32'(exp_d));
            end
        end

        // Zero delay is primed immediately and passes samples bit-exact.
        load(0);
        push(1'b0, 16'hDEAD);
        check("t3_delay_cur", 32'(delay_cur), 32'(0));
        check("t3_primed",    32'(primed), 32'(1));
        for (int i = 0; i < 6; i++) begin
            push(1'b1, pat[i]);
            check("t3_valid", 32'(valid_out), 32'(1));
            check("t3_dout",  32'(dout), 32'(pat[i]));
        end

        // Delay 10 with the half-delay tap.
        load(10);
        push(1'b0, 16'hDEAD);
        for (int k = 1; k <= 16; k++) begin
            n++;
            push(1'b1, WIDTH'(n));
            check("t6_valid", 32'(valid_out), 32'(k >= 11));
            check("t6_dout",  32'(dout), 32'((k >= 11) ? n - 10 : 0));
`ifdef PDL_MID_TAP_EN
            check("t6_mid",   32'(dout_mid), 32'((k >= 11) ? n - 5 : 0));
`else
            check("t6_mid",   32'(dout_mid), 32'(0));
`endif
        end

        // Reset in the middle of a stream drops the in-flight output.
        rst = 1'b1;
        n++;
        push(1'b1, WIDTH'(n));
        rst = 1'b0;
        check("t6_rst_dout",      32'(dout), 32'(0));
        check("t6_rst_valid",     32'(valid_out), 32'(0));
        check("t6_rst_primed",    32'(primed), 32'(0));
        check("t6_rst_delay_cur", 32'(delay_cur), 32'(31));
        check("t6_rst_mid",       32'(dout_mid), 32'(0));
        for (int k = 1; k <= 33; k++) begin
            n++;
            push(1'b1, WIDTH'(n));
            check("t6_post_valid", 32'(valid_out), 32'(k >= 32));
            check("t6_post_dout",  32'(dout), 32'((k >= 32) ? n - 31 : 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
